// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
// One iteration per clock: BIN_W iterations per operand, valid/ready on
// both the operand side and the result side. No input/output bypass: a
// new operand is only accepted once the previous result has been taken.
module bcd_seq_converter #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int REG_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // True when DIGITS decimal digits can hold every BIN_W-bit value.
  function automatic bit digits_fit(input int bw, input int dg);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10 = 1;
    for (int i = 0; i < dg; i++) pow10 = pow10 * 10;
    max_bin = (longint'(1) << bw) - 1;
    return pow10 > max_bin;
  endfunction

  // Reject parameter sets that cannot be converted correctly.
  if (BIN_W < 2) begin : g_bad_width
    $error("bcd_seq_converter: BIN_W must be at least 2");
  end
  if (!digits_fit(BIN_W, DIGITS)) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [REG_W-1:0]   shift_reg;
  logic [REG_W-1:0]   shift_next;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   iter_cnt;
  logic [BCD_W-1:0]   bcd_q;
  logic               accept;
  logic               last_iter;

  assign accept    = in_valid && in_ready;
  // The edge that performs iteration BIN_W sees the counter at BIN_W-1.
  assign last_iter = (iter_cnt == CNT_W'(BIN_W - 1));
  assign bcd_out   = bcd_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // variable unassigned, which would infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = SHIFT;
      SHIFT:   if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded purely from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:  in_ready  = 1'b1;
      SHIFT: busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // One double-dabble iteration: add 3 to every digit >= 5 (all digits judged
  // on pre-shift values), then shift the whole {BCD, binary} register left.
  always_comb begin
    bcd_adj = shift_reg[REG_W-1:BIN_W];
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_adj[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
    end
    shift_next = {bcd_adj, shift_reg[BIN_W-1:0]} << 1;
  end

  // Datapath: operand capture, iteration, and result latch. The result
  // register only moves on the SHIFT->DONE edge so it holds through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      iter_cnt  <= '0;
      bcd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= {{BCD_W{1'b0}}, bin_in};
            iter_cnt  <= '0;
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          iter_cnt  <= iter_cnt + CNT_W'(1);
          if (last_iter) bcd_q <= shift_next[REG_W-1:BIN_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: table-driven conversions,
// hand-written handshake/reset sequences, random operands and exhaustive
// sweeps on an 8-bit/3-digit and a 5-bit/2-digit instance.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd_out;
  logic        busy;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [4:0]  s_bin_in;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_bcd_out;
  logic        s_busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out),
    .busy(busy)
  );

  bcd_seq_converter #(.BIN_W(5), .DIGITS(2)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .bin_in(s_bin_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .bcd_out(s_bcd_out),
    .busy(s_busy)
  );

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [11:0] ref_bcd3(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] ref_bcd2(input int n);
    return {4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the first negedge after the accepting edge. Checks latency and
  // result, holds out_ready low for `hold` cycles, then handshakes.
  task automatic wait_result(input logic [11:0] exp, input int hold, input string name);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, 8);
    check({name, " bcd_out"}, bcd_out, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " held out_valid"}, out_valid, 1);
      check({name, " held bcd_out"}, bcd_out, exp);
      check({name, " held in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid cleared"}, out_valid, 0);
    check({name, " in_ready back"}, in_ready, 1);
  endtask

  task automatic run_one(input logic [7:0] n, input logic [11:0] exp, input int hold, input string name);
    @(negedge clk);
    check({name, " ready before"}, in_ready, 1);
    in_valid  = 1'b1;
    bin_in    = n;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    bin_in   = 8'($urandom);  // must not disturb the captured operand
    wait_result(exp, hold, name);
  endtask

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    int          hold;
  } vec_t;

  vec_t table_v[10];

  initial begin
    int prev;
    int t;
    logic [7:0] r;

    table_v[0] = '{8'd0,   12'h000, 0};
    table_v[1] = '{8'd255, 12'h255, 0};
    table_v[2] = '{8'd99,  12'h099, 5};
    table_v[3] = '{8'd1,   12'h001, 1};
    table_v[4] = '{8'd9,   12'h009, 0};
    table_v[5] = '{8'd10,  12'h010, 2};
    table_v[6] = '{8'd100, 12'h100, 0};
    table_v[7] = '{8'd199, 12'h199, 1};
    table_v[8] = '{8'd250, 12'h250, 0};
    table_v[9] = '{8'd64,  12'h064, 3};

    // Reset held two cycles with a valid operand present.
    rst = 1'b1; in_valid = 1'b1; bin_in = 8'd77; out_ready = 1'b0;
    s_in_valid = 1'b0; s_bin_in = '0; s_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset out_valid", out_valid, 0);
      check("reset bcd_out", bcd_out, 12'h000);
      check("reset busy", busy, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    check("post-reset in_ready", in_ready, 1);
    @(negedge clk);
    check("post-reset idle", busy, 0);
    check("post-reset bcd_out", bcd_out, 12'h000);

    // Table-driven conversions, including backpressure holds.
    foreach (table_v[i]) run_one(table_v[i].bin, table_v[i].bcd, table_v[i].hold, "table");

    // Operand stays valid during the whole conversion: ignored until handshake.
    @(negedge clk);
    in_valid = 1'b1; bin_in = 8'd128;
    @(negedge clk);
    bin_in = 8'd3;
    for (int i = 0; i < 8; i++) begin
      check("busy-ignore in_ready", in_ready, 0);
      check("busy-ignore busy", busy, 1);
      check("busy-ignore out_valid", out_valid, 0);
      @(negedge clk);
    end
    check("busy-ignore result valid", out_valid, 1);
    check("busy-ignore result", bcd_out, 12'h128);
    @(negedge clk);
    check("busy-ignore done in_ready", in_ready, 0);
    check("busy-ignore done bcd", bcd_out, 12'h128);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("second transfer ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(12'h003, 0, "second transfer");

    // Reset during iteration 4 aborts the conversion and clears the result.
    @(negedge clk);
    in_valid = 1'b1; bin_in = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort bcd_out", bcd_out, 12'h000);
    check("abort in_ready", in_ready, 1);
    t = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) t++;
    end
    check("abort no out_valid", t, 0);
    run_one(8'd42, 12'h042, 0, "after abort");

    // Random operands with random backpressure.
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom_range(0, 255));
      run_one(r, ref_bcd3(int'(r)), int'($urandom_range(0, 3)), "random");
    end

    // Exhaustive 8-bit sweep, in_valid and out_ready held high.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; prev = 0;
    for (int n = 0; n < 256; n++) begin
      t = 0;
      while (!in_ready && t < 40) begin @(negedge clk); t++; end
      bin_in = 8'(n);
      if (n > 0) check("sweep8 spacing", cyc - prev, 10);
      prev = cyc;
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 40) begin @(negedge clk); t++; end
      check("sweep8 result", bcd_out, ref_bcd3(n));
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Exhaustive 5-bit sweep on the two-digit instance.
    @(negedge clk);
    s_in_valid = 1'b1; s_out_ready = 1'b1; prev = 0;
    for (int n = 0; n < 32; n++) begin
      t = 0;
      while (!s_in_ready && t < 40) begin @(negedge clk); t++; end
      s_bin_in = 5'(n);
      if (n > 0) check("sweep5 spacing", cyc - prev, 7);
      prev = cyc;
      @(negedge clk);
      t = 0;
      while (!s_out_valid && t < 40) begin @(negedge clk); t++; end
      check("sweep5 result", s_bcd_out, ref_bcd2(n));
    end
    s_in_valid = 1'b0; s_out_ready = 1'b0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, with a valid/ready handshake on input and output.
- Replaces the wide combinational converter where the binary operand is wider than 5 bits and area matters more than latency.
- Owns the FSM, iteration counter and shift register.
- Sits between a binary producer (counter, ADC sample register) and display/UART digit logic.

Parameters:
- BIN_W, 8, binary input width in bits (≥2).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W − 1; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept an operand.
- bin_in  input  BIN_W  unsigned binary operand.
- out_valid  output  1  bcd_out holds a completed result.
- out_ready  input  1  consumer accepts the result.
- bcd_out  output  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], digit 0 = units.
- busy  output  1  high in SHIFT and DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high, sampled on the clk rising edge; it overrides all other inputs.
- Reset values: state=IDLE, out_valid=0, bcd_out=0, busy=0, counter=0, shift register=0. in_ready=1 from the first cycle after reset deasserts.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. On in_valid & in_ready at an edge, load {BCD field=0, bin field=bin_in} and counter=0, then go to SHIFT.
  - SHIFT: in_ready=0. Each edge performs one iteration:
    - Every BCD digit ≥5 gets +3 (evaluated on pre-shift values, all digits in parallel).
    - Then the whole {BCD, bin} register shifts left by 1.
    - counter increments.
    - The edge completing iteration BIN_W copies the BCD field to bcd_out, sets out_valid=1 and goes to DONE.
  - DONE: out_valid=1; bcd_out stable. On out_valid & out_ready, clear out_valid and go to IDLE.
- Latency: out_valid rises exactly BIN_W cycles after the accepting edge. Minimum period between accepts is BIN_W+2 cycles, because in_ready stays low in DONE even when out_ready=1 (no bypass).
- in_valid/bin_in are ignored outside IDLE. The operand is captured only at the accepting edge, so later bin_in changes have no effect.
- bcd_out changes only on the SHIFT→DONE edge or on reset; it holds the last result while in IDLE.
- out_ready is ignored when out_valid=0.
- Arithmetic: internal register width is 4*DIGITS+BIN_W. Counter width is clog2(BIN_W+1). Each digit's add-3 is 4-bit and never overflows, since the corrected value is ≤12.
- Boundaries:
  - bin_in=0 yields all-zero digits.
  - bin_in=2^BIN_W−1 must convert exactly (e.g. 255→0x255).
  - rst in SHIFT or DONE aborts: no out_valid, state returns to IDLE, and bcd_out clears to 0.
  - rst coincident with in_valid: rst wins, nothing is captured.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, bin_in=8'd77 → during and after reset out_valid=0, bcd_out=12'h000, busy=0; in_ready=1 in the first cycle after reset.
- Single conversions: accept bin_in=0, then 8'd255 → out_valid rises exactly 8 cycles after each accepting edge; bcd_out=12'h000 and 12'h255 respectively.
- Backpressure: accept 8'd99 with out_ready=0 for 5 cycles after out_valid → bcd_out=12'h099 stable and out_valid held; one cycle of out_ready=1 → out_valid=0 and in_ready=1 next cycle.
- Busy-ignore:
  - Accept 8'd128, then drive in_valid=1 with bin_in=8'd3 for the whole conversion → result 12'h128; in_ready=0 throughout.
  - A second transfer occurs only after DONE handshake.
- Reset mid-operation: accept 8'd200, assert rst at iteration 4 → no out_valid ever asserts; bcd_out=12'h000. A subsequent accept of 8'd42 → 12'h042.
- Exhaustive sweep: 0..255 with out_ready=1 and in_valid=1 continuously → every result equals {n/100, (n/10)%10, n%10}; accept spacing is exactly 10 cycles. Repeat the sweep with BIN_W=5, DIGITS=2 over 0..31.
